// File: rtl/mpf_vtp_pkg.sv
// ---------------------------------------------------------------------------
// mpf_vtp_pkg
// Shared types for the VTP software page-table walker host I/O path.
//   t_cci_clAddr          : 42-bit CCI cache-line address
//   t_cci_clData          : 512-bit CCI cache-line data
//   t_mpf_vtp_pt_host_wr  : one buffered walker write {addr, data}
//   VTP_PT_RSP_*_BIT      : bit positions inside a translation response word
//   t_host_io_state       : RUN / DRAIN state of the host I/O shim
// ---------------------------------------------------------------------------
package mpf_vtp_pkg;

  localparam int CCI_CLADDR_WIDTH = 42;
  localparam int CCI_CLDATA_WIDTH = 512;
  localparam int VTP_PT_WORD_WIDTH = 64;

  typedef logic [CCI_CLADDR_WIDTH-1:0] t_cci_clAddr;
  typedef logic [CCI_CLDATA_WIDTH-1:0] t_cci_clData;

  typedef struct packed {
    t_cci_clAddr                  addr;
    logic [VTP_PT_WORD_WIDTH-1:0] data;
  } t_mpf_vtp_pt_host_wr;

  localparam int VTP_PT_RSP_NOT_PRESENT_BIT = 0;
  localparam int VTP_PT_RSP_BIG_PAGE_BIT    = 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } t_host_io_state;

  // A walker write only ever fills the low 64 bits of a host line.
  function automatic t_cci_clData host_wr_line(input logic [VTP_PT_WORD_WIDTH-1:0] word);
    return {{(CCI_CLDATA_WIDTH-VTP_PT_WORD_WIDTH){1'b0}}, word};
  endfunction

endpackage

// File: rtl/cci_mpf_prim_fifo_lutram.sv
// ---------------------------------------------------------------------------
// cci_mpf_prim_fifo_lutram
// Small distributed-RAM FIFO.
//   clk, reset (async, active-high)
//   enq_data / enq_en : push (ignored when full)
//   notFull           : space for at least one entry
//   first             : head entry (fall-through when REGISTER_OUTPUT=0)
//   deq_en            : pop head (ignored when empty)
//   notEmpty          : at least one entry present
// Parameters: N_DATA_BITS, N_ENTRIES (power of 2, >=2), REGISTER_OUTPUT.
// ---------------------------------------------------------------------------
module cci_mpf_prim_fifo_lutram #(
  parameter int N_DATA_BITS     = 32,
  parameter int N_ENTRIES       = 4,
  parameter int REGISTER_OUTPUT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_DATA_BITS-1:0] enq_data,
  input  logic                   enq_en,
  output logic                   notFull,
  output logic [N_DATA_BITS-1:0] first,
  input  logic                   deq_en,
  output logic                   notEmpty
);

  localparam int AW = $clog2(N_ENTRIES);
  localparam int CW = $clog2(N_ENTRIES + 1);

  logic [N_DATA_BITS-1:0] r_mem [N_ENTRIES];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   w_enq;
  logic                   w_deq;

  assign notFull  = (r_count != CW'(N_ENTRIES));
  assign notEmpty = (r_count != '0);
  assign w_enq    = enq_en && notFull;
  assign w_deq    = deq_en && notEmpty;

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wr_ptr] <= enq_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  generate
    if (REGISTER_OUTPUT == 0) begin : g_comb_out
      assign first = r_mem[r_rd_ptr];
    end else begin : g_reg_out
      // Pre-read the slot that will be the head after this edge; bypass the
      // incoming word when it lands in exactly that slot (FIFO was emptying).
      logic [AW-1:0]          w_rd_ptr_next;
      logic [N_DATA_BITS-1:0] r_first;
      assign w_rd_ptr_next = r_rd_ptr + AW'(w_deq);
      always_ff @(posedge clk) begin
        r_first <= (w_enq && (r_wr_ptr == w_rd_ptr_next)) ? enq_data : r_mem[w_rd_ptr_next];
      end
      assign first = r_first;
    end
  endgenerate

endmodule

// File: rtl/mpf_vtp_pt_sw_host_io.sv
// ---------------------------------------------------------------------------
// mpf_vtp_pt_sw_host_io
// Host I/O shim below the software page-table walker.
//   write_en/addr/data, write_rdy : walker ring-buffer writes into a FIFO
//   c1_tx_valid/addr/data         : single-line host writes (1-cycle pulses)
//   c1_almost_full, c1_rx_wr_ack  : host channel back-pressure / completions
//   buf_paddr_valid               : ring address changed -> drain in-flight writes
//   rsp_in_valid/data             : host translation response (CSR write)
//   read_data_en/read_data        : registered response strobe to the walker
//   drain_busy, err_ack_underflow : status
//   stat_writes, stat_rsps        : counters, live only with
//                                   MPF_VTP_PT_SW_HOST_IO_STATS_EN defined
// Parameters: FIFO_DEPTH (power of 2, >=2), MAX_OUTSTANDING (>=1).
// ---------------------------------------------------------------------------
module mpf_vtp_pt_sw_host_io
  import mpf_vtp_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         write_en,
  input  logic [41:0]  write_addr,
  input  logic [63:0]  write_data,
  output logic         write_rdy,
  output logic         c1_tx_valid,
  output logic [41:0]  c1_tx_addr,
  output logic [511:0] c1_tx_data,
  input  logic         c1_almost_full,
  input  logic         c1_rx_wr_ack,
  input  logic         buf_paddr_valid,
  input  logic         rsp_in_valid,
  input  logic [63:0]  rsp_in_data,
  output logic         read_data_en,
  output logic [63:0]  read_data,
  output logic         drain_busy,
  output logic         err_ack_underflow,
  output logic [31:0]  stat_writes,
  output logic [31:0]  stat_rsps
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  t_host_io_state      r_state;
  logic                r_tx_valid;
  t_cci_clAddr         r_tx_addr;
  logic [63:0]         r_tx_word;
  logic [OW-1:0]       r_outstanding;
  logic                r_err_underflow;
  logic                r_rd_en;
  logic [63:0]         r_rd_data;

  t_mpf_vtp_pt_host_wr w_enq_entry;
  t_mpf_vtp_pt_host_wr w_head;
  logic                w_fifo_not_full;
  logic                w_fifo_not_empty;
  logic                w_enq;
  logic                w_issue;

  // Gated by reset so every output reads 0 while reset is held.
  assign write_rdy   = !reset && (r_state == ST_RUN) && w_fifo_not_full;
  assign w_enq       = write_en && write_rdy;
  assign w_enq_entry = '{addr: write_addr, data: write_data};
  assign w_issue     = w_fifo_not_empty && !c1_almost_full && (r_outstanding < MAX_OUT);

  cci_mpf_prim_fifo_lutram #(
    .N_DATA_BITS     ($bits(t_mpf_vtp_pt_host_wr)),
    .N_ENTRIES       (FIFO_DEPTH),
    .REGISTER_OUTPUT (0)
  ) u_wr_fifo (
    .clk      (clk),
    .reset    (reset),
    .enq_data (w_enq_entry),
    .enq_en   (w_enq),
    .notFull  (w_fifo_not_full),
    .first    (w_head),
    .deq_en   (w_issue),
    .notEmpty (w_fifo_not_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_RUN;
      r_tx_valid      <= 1'b0;
      r_tx_addr       <= '0;
      r_tx_word       <= '0;
      r_outstanding   <= '0;
      r_err_underflow <= 1'b0;
      r_rd_en         <= 1'b0;
      r_rd_data       <= '0;
    end else begin
      // Host write issue stage
      r_tx_valid <= w_issue;
      if (w_issue) begin
        r_tx_addr <= w_head.addr;
        r_tx_word <= w_head.data;
      end

      // Outstanding writes; an ack at zero is a host protocol error
      case ({w_issue, c1_rx_wr_ack})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      if (c1_rx_wr_ack && (r_outstanding == '0)) r_err_underflow <= 1'b1;

      // Drain: wait until nothing is queued, on the wire, or unacknowledged.
      case (r_state)
        ST_RUN:   if (buf_paddr_valid) r_state <= ST_DRAIN;
        ST_DRAIN: if (!w_fifo_not_empty && (r_outstanding == '0) && !r_tx_valid)
                    r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase

      // Response path is independent of the write side
      r_rd_en <= rsp_in_valid;
      if (rsp_in_valid) r_rd_data <= rsp_in_data;
    end
  end

  assign c1_tx_valid       = r_tx_valid;
  assign c1_tx_addr        = r_tx_addr;
  assign c1_tx_data        = host_wr_line(r_tx_word);
  assign read_data_en      = r_rd_en;
  assign read_data         = r_rd_data;
  assign drain_busy        = (r_state == ST_DRAIN);
  assign err_ack_underflow = r_err_underflow;

`ifdef MPF_VTP_PT_SW_HOST_IO_STATS_EN
  logic [31:0] r_stat_writes;
  logic [31:0] r_stat_rsps;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_writes <= '0;
      r_stat_rsps   <= '0;
    end else begin
      if (w_issue)      r_stat_writes <= r_stat_writes + 32'd1;
      if (rsp_in_valid) r_stat_rsps   <= r_stat_rsps + 32'd1;
    end
  end

  assign stat_writes = r_stat_writes;
  assign stat_rsps   = r_stat_rsps;
`else
  assign stat_writes = '0;
  assign stat_rsps   = '0;
`endif

endmodule

// File: tb/tb_mpf_vtp_pt_sw_host_io.sv
// ---------------------------------------------------------------------------
// tb_mpf_vtp_pt_sw_host_io
// Randomized scoreboard bench for mpf_vtp_pt_sw_host_io. The driver keeps a
// transaction-level model (pending count, outstanding count, drain flag) and
// pushes expected host writes / responses into queues; a separate monitor
// pops and compares whenever the DUT presents c1_tx_valid or read_data_en.
// ---------------------------------------------------------------------------
module tb_mpf_vtp_pt_sw_host_io;

  localparam int FIFO_DEPTH      = 4;
  localparam int MAX_OUTSTANDING = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         write_en = 1'b0;
  logic [41:0]  write_addr = '0;
  logic [63:0]  write_data = '0;
  logic         write_rdy;
  logic         c1_tx_valid;
  logic [41:0]  c1_tx_addr;
  logic [511:0] c1_tx_data;
  logic         c1_almost_full = 1'b0;
  logic         c1_rx_wr_ack = 1'b0;
  logic         buf_paddr_valid = 1'b0;
  logic         rsp_in_valid = 1'b0;
  logic [63:0]  rsp_in_data = '0;
  logic         read_data_en;
  logic [63:0]  read_data;
  logic         drain_busy;
  logic         err_ack_underflow;
  logic [31:0]  stat_writes;
  logic [31:0]  stat_rsps;

  mpf_vtp_pt_sw_host_io #(
    .FIFO_DEPTH      (FIFO_DEPTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .write_en          (write_en),
    .write_addr        (write_addr),
    .write_data        (write_data),
    .write_rdy         (write_rdy),
    .c1_tx_valid       (c1_tx_valid),
    .c1_tx_addr        (c1_tx_addr),
    .c1_tx_data        (c1_tx_data),
    .c1_almost_full    (c1_almost_full),
    .c1_rx_wr_ack      (c1_rx_wr_ack),
    .buf_paddr_valid   (buf_paddr_valid),
    .rsp_in_valid      (rsp_in_valid),
    .rsp_in_data       (rsp_in_data),
    .read_data_en      (read_data_en),
    .read_data         (read_data),
    .drain_busy        (drain_busy),
    .err_ack_underflow (err_ack_underflow),
    .stat_writes       (stat_writes),
    .stat_rsps         (stat_rsps)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard queues
  logic [105:0] wr_q[$];
  logic [63:0]  rsp_q[$];

  // Reference model state
  int          m_pend   = 0;
  int          m_out    = 0;
  bit          m_drain  = 0;
  bit          m_txv    = 0;
  bit          m_err    = 0;
  bit          m_rsp_v  = 0;
  logic [63:0] m_rsp_d  = '0;
  int          m_nwr    = 0;
  int          m_nrsp   = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_out = 0; m_drain = 0; m_txv = 0; m_err = 0;
    m_rsp_v = 0; m_rsp_d = '0; m_nwr = 0; m_nrsp = 0;
    wr_q.delete();
    rsp_q.delete();
  endtask

  task automatic check_outputs();
    chk("write_rdy", write_rdy, !reset && !m_drain && (m_pend < FIFO_DEPTH));
    chk("drain_busy", drain_busy, m_drain);
    chk("c1_tx_valid", c1_tx_valid, m_txv);
    chk("err_ack_underflow", err_ack_underflow, m_err);
    chk("read_data_en", read_data_en, m_rsp_v);
    chk("read_data", read_data, m_rsp_d);
  endtask

  // Apply inputs for the coming edge and advance the model across it.
  task automatic drive(input bit we, input bit bpv, input bit af, input bit ack,
                       input bit rv, input logic [63:0] rd);
    logic [41:0] a;
    logic [63:0] d;
    bit rdy, acc, iss, nd;
    a = 42'({$urandom(), $urandom()});
    d = {$urandom(), $urandom()};
    write_en = we; write_addr = a; write_data = d;
    buf_paddr_valid = bpv; c1_almost_full = af; c1_rx_wr_ack = ack;
    rsp_in_valid = rv; rsp_in_data = rd;

    rdy = !m_drain && (m_pend < FIFO_DEPTH);
    acc = we && rdy;
    iss = (m_pend > 0) && !af && (m_out < MAX_OUTSTANDING);
    if (acc) wr_q.push_back({a, d});
    if (rv)  rsp_q.push_back(rd);
    nd = m_drain;
    if (!m_drain) begin
      if (bpv) nd = 1;
    end else if (m_pend == 0 && m_out == 0 && !m_txv) begin
      nd = 0;
    end
    if (ack && m_out == 0) m_err = 1;
    if (iss && !ack) m_out++;
    else if (ack && !iss && m_out > 0) m_out--;
    m_pend = m_pend + int'(acc) - int'(iss);
    m_drain = nd;
    m_txv = iss;
    m_nwr += int'(iss);
    m_rsp_v = rv;
    if (rv) m_rsp_d = rd;
    m_nrsp += int'(rv);
  endtask

  task automatic do_cycle(input bit we, input bit bpv, input bit af, input bit ack,
                          input bit rv, input logic [63:0] rd);
    @(negedge clk);
    check_outputs();
    drive(we, bpv, af, ack, rv, rd);
  endtask

  function automatic bit pct(input int p);
    return ($urandom_range(99) < p);
  endfunction

  // Monitor: pops expected transactions whenever the DUT presents one.
  initial begin
    logic [105:0] e;
    logic [63:0]  r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (c1_tx_valid) begin
          if (wr_q.size() == 0) begin
            chk("unexpected_c1_tx_valid", 1'b1, 1'b0);
          end else begin
            e = wr_q.pop_front();
            $display("host write addr=%0h data=%0h", c1_tx_addr, c1_tx_data[63:0]);
            chk("c1_tx_addr", c1_tx_addr, e[105:64]);
            chk("c1_tx_data", c1_tx_data, {448'b0, e[63:0]});
          end
        end
        if (read_data_en) begin
          if (rsp_q.size() == 0) begin
            chk("unexpected_read_data_en", 1'b1, 1'b0);
          end else begin
            r = rsp_q.pop_front();
            $display("response data=%0h", read_data);
            chk("read_data_strobe", read_data, r);
          end
        end
      end
    end
  end

  initial begin
    bit ack;
    int i;
    // Reset state
    #1;
    chk("rst_c1_tx_valid", c1_tx_valid, 1'b0);
    chk("rst_write_rdy", write_rdy, 1'b0);
    chk("rst_drain_busy", drain_busy, 1'b0);
    chk("rst_read_data_en", read_data_en, 1'b0);
    chk("rst_err", err_ack_underflow, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, '0);

    for (int c = 0; c < 600; c++) begin
      bit we, bpv, af, rv;
      logic [63:0] rd;
      we = pct(55); bpv = 0; af = pct(10); rv = pct(40);
      rd = {$urandom(), $urandom()};
      ack = (m_out > 0) && pct(40);
      if (c >= 200 && c < 240) begin      // host back-pressure fills the FIFO
        af = 1; we = pct(80);
      end else if (c >= 300 && c < 380) begin  // no completions: saturate outstanding
        af = 0; ack = 0; we = pct(70);
      end else if (c >= 450) begin        // ring reprogramming while busy
        bpv = pct(5); ack = (m_out > 0) && pct(50);
      end else begin
        bpv = pct(2);
      end
      if (c == 458) bpv = 1;
      if (c == 460) begin rv = 1; rd = 64'h1003; end
      if (c == 461) begin rv = 1; rd = 64'h2001; end
      do_cycle(we, bpv, af, ack, rv, rd);
    end

    // Flush everything, bounded
    i = 0;
    while (i < 300 && !(m_pend == 0 && m_out == 0 && !m_txv && !m_drain)) begin
      do_cycle(0, 0, 0, m_out > 0, 0, '0);
      i++;
    end
    do_cycle(0, 0, 0, 0, 0, '0);
    do_cycle(0, 0, 0, 0, 0, '0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
`ifdef MPF_VTP_PT_SW_HOST_IO_STATS_EN
    chk("stat_writes", stat_writes, 32'(m_nwr));
    chk("stat_rsps", stat_rsps, 32'(m_nrsp));
`else
    chk("stat_writes_off", stat_writes, 32'd0);
    chk("stat_rsps_off", stat_rsps, 32'd0);
`endif

    // Ack with nothing outstanding: sticky error
    do_cycle(0, 0, 0, 1, 0, '0);
    for (int k = 0; k < 5; k++) do_cycle(0, 0, 0, 0, 0, '0);

    // Reset in the middle of a drain
    do_cycle(1, 0, 1, 0, 0, '0);
    do_cycle(1, 0, 1, 0, 0, '0);
    do_cycle(0, 1, 1, 0, 1, 64'hDEAD_BEEF);
    do_cycle(0, 0, 1, 0, 0, '0);
    @(negedge clk);
    check_outputs();
    drive(0, 0, 0, 0, 0, '0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("rst_mid_c1_tx_addr", c1_tx_addr, 42'd0);
    chk("rst_mid_c1_tx_data", c1_tx_data, 512'd0);
    chk("rst_mid_stat_writes", stat_writes, 32'd0);
    chk("rst_mid_stat_rsps", stat_rsps, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, '0);
    for (int k = 0; k < 3; k++) do_cycle(0, 0, 0, 0, 0, '0);
    do_cycle(1, 0, 0, 0, 0, '0);
    for (int k = 0; k < 4; k++) do_cycle(0, 0, 0, m_out > 0, 0, '0);
    @(negedge clk);
    check_outputs();
    chk("post_reset_wr_q", 32'(wr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global safety bound
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mpf_vtp_pt_sw_host_io.md
Name: mpf_vtp_pt_sw_host_io

Overview:
Host I/O shim directly downstream of the software page-table walker (mpf_svc_vtp_pt_sw).
- Takes the walker's 64-bit ring-buffer write requests and issues them as single-line CCI write requests, with bounded outstanding writes.
- Returns host-written translation responses to the walker as a registered read-data strobe.
- Drains in-flight writes whenever software reprograms the request ring buffer address.

Parameters:
FIFO_DEPTH, 4, write-request buffer entries (power of 2, >=2)
MAX_OUTSTANDING, 8, max issued-but-unacked host writes (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
write_en  in  1  walker write request, valid only when write_rdy=1
write_addr  in  42  line address (t_cci_clAddr)
write_data  in  64  request word
write_rdy  out  1  shim can accept write_en this cycle
c1_tx_valid  out  1  host write request valid (one-cycle pulse)
c1_tx_addr  out  42  host write line address
c1_tx_data  out  512  line data: write_data in [63:0], zeros above
c1_almost_full  in  1  host write channel back-pressure
c1_rx_wr_ack  in  1  one write completion
buf_paddr_valid  in  1  CSR pulse: ring buffer address changed
rsp_in_valid  in  1  host translation response arrived (CSR write)
rsp_in_data  in  64  response word (bit0 not-present, bit1 big page)
read_data_en  out  1  response strobe to walker
read_data  out  64  response word to walker
drain_busy  out  1  high while in DRAIN
err_ack_underflow  out  1  sticky: ack received with zero outstanding
stat_writes  out  32  issued write count (feature only)
stat_rsps  out  32  response count (feature only)

Behaviour:
Reset (asynchronous, active-high):
- All outputs 0, state RUN, FIFO empty, outstanding counter 0.

write_rdy:
- write_rdy = (state==RUN) && (fifo_count < FIFO_DEPTH). Combinational from registered state.
- write_en while write_rdy=0 is a protocol error and is dropped.

Write path:
- Accepted writes are enqueued in FIFO {addr, data}.
- Issue condition: FIFO not empty && !c1_almost_full && outstanding < MAX_OUTSTANDING.
- On issue: dequeue the head; next cycle c1_tx_valid=1 with its addr/data.
- Latency: write accepted in cycle N -> c1_tx_valid earliest in cycle N+2. One issue per cycle maximum; strict FIFO order.

Outstanding counter (width $clog2(MAX_OUTSTANDING+1)):
- +1 on issue, -1 on c1_rx_wr_ack; unchanged if both occur in the same cycle.
- Ack arriving with counter 0: counter stays 0 and err_ack_underflow is set; cleared only by reset.

FSM:
- RUN -> DRAIN on buf_paddr_valid.
- DRAIN: write_rdy=0; issuing continues normally.
- DRAIN -> RUN the cycle after FIFO empty && outstanding==0 && c1_tx_valid==0.
- buf_paddr_valid while in DRAIN: no effect.
- write_en in the same cycle as a buf_paddr_valid arriving in RUN: the write is accepted (write_rdy was 1) and is drained.
- drain_busy = (state==DRAIN).

Response path:
- read_data_en <= rsp_in_valid; read_data <= rsp_in_data when rsp_in_valid (held otherwise).
- 1-cycle latency; back-to-back accepted every cycle; independent of FSM state and back-pressure.

Optional Feature:
MPF_VTP_PT_SW_HOST_IO_STATS_EN
- Defined: stat_writes increments per issued write; stat_rsps increments per rsp_in_valid. Both are 32-bit wrapping counters reset to 0.
- Undefined: both ports are tied to constant 0 and no counter logic exists.

Decomposition:
- Shared package (mpf_vtp_pkg): t_mpf_vtp_pt_host_wr struct {t_cci_clAddr addr; logic [63:0] data}; response bit positions VTP_PT_RSP_NOT_PRESENT_BIT=0, VTP_PT_RSP_BIG_PAGE_BIT=1.
- Sub-module: the FIFO is the existing cci_mpf_prim_fifo_lutram (N_ENTRIES=FIFO_DEPTH, REGISTER_OUTPUT=0). No new sub-module.

Test Plan:
- 3 writes (addr 0x100..0x102, data 0xA1..0xA3), c1_almost_full=0 -> c1_tx_valid on cycles N+2..N+4, same order; c1_tx_data[63:0]=0xA1.., upper bits 0.
- c1_almost_full=1, 5 writes attempted with FIFO_DEPTH=4 -> 4 accepted, write_rdy=0 after the 4th; release almost_full -> 4 issues, then write_rdy=1.
- No acks, 10 writes -> exactly 8 issued; 1 ack -> 9th issued; ack+issue in same cycle -> counter stays at 8.
- 2 writes pending, buf_paddr_valid pulse -> drain_busy=1, write_rdy=0; after both issued and 2 acks -> RUN one cycle later, drain_busy=0.
- rsp_in_valid 2 consecutive cycles with 0x1003 then 0x2001 -> read_data_en 2 cycles, read_data 0x1003 then 0x2001, including during DRAIN.
- Ack with outstanding 0 -> err_ack_underflow=1 and stays 1; assert reset mid-drain -> all outputs 0 immediately, state RUN.
